gray2rgb_out: RTL and testbench
===============================

GRAY2RGB_OUT -- requirements
Module: gray2rgb_out

Interface
REQ-001 Parameter IMG_W, default 320, active pixels per line (>=2).
REQ-002 Parameter IMG_H, default 240, lines per frame (>=2).
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  upstream pixel valid.
REQ-006 i_ready  output  1  block can accept a pixel this cycle.
REQ-007 i_data  input  8  grayscale or edge-magnitude pixel.
REQ-008 i_mode  input  2  00 replicate, 01 binary threshold, 10 inverted replicate, 11 same as 00.
REQ-009 i_thresh  input  8  threshold for mode 01.
REQ-010 o_valid  output  1  RGB444 pixel available.
REQ-011 o_ready  input  1  downstream (display side) accepts pixel.
REQ-012 o_data  output  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-013 o_sof  output  1  current o_data is first pixel of frame.
REQ-014 o_eol  output  1  current o_data is last pixel of line.
REQ-015 o_eof  output  1  current o_data is last pixel of frame.

Function
REQ-016 Input handshake SHALL complete when i_valid & i_ready on a rising edge; output handshake SHALL complete when o_valid & o_ready on a rising edge.
REQ-017 Conversion, with n = i_data[7:4]: mode 00/11 -> {n,n,n}; mode 10 -> {~n,~n,~n}; mode 01 -> 12'hFFF if i_data >= i_thresh (unsigned), else 12'h000.
REQ-018 i_mode and i_thresh SHALL be sampled per pixel at the input handshake; changes affect only later pixels.
REQ-019 Converted pixels SHALL be stored in a 4-entry FIFO (write pointer, read pointer, 3-bit count 0..4).
REQ-020 i_ready SHALL equal (count != 4) and RST high; no pass-through when full, even if o_ready is high.
REQ-021 o_valid SHALL equal (count != 0); o_data SHALL show the FIFO head entry, held stable while o_valid & !o_ready.
REQ-022 Latency: a pixel accepted at edge N SHALL appear on o_data with o_valid high in the cycle after edge N when the FIFO was empty.
REQ-023 Simultaneous input and output handshake SHALL leave count unchanged; pointers wrap modulo 4.
REQ-024 Pixel order SHALL be preserved; no pixel dropped or duplicated.
REQ-025 Column counter (0..IMG_W-1) and row counter (0..IMG_H-1) SHALL advance only on output handshake; column wraps to 0 and row increments at IMG_W-1; both wrap to 0 after the last pixel of the frame.
REQ-026 o_sof = o_valid & col==0 & row==0; o_eol = o_valid & col==IMG_W-1; o_eof = o_eol & row==IMG_H-1; all combinational from counters and o_valid.
REQ-027 When o_valid is low, o_data SHALL be 12'h000 and o_sof/o_eol/o_eof low.

Reset
REQ-028 While RST is low at a rising edge: FIFO count and pointers, column and row counters SHALL clear to 0.
REQ-029 During and after reset: o_valid=0, o_data=12'h000, o_sof=o_eol=o_eof=0; i_ready=0 while RST low, 1 in the first cycle after RST goes high.
REQ-030 Reset mid-frame or with a non-empty FIFO SHALL discard all buffered pixels; the next output pixel after reset SHALL carry o_sof=1.

Verification
REQ-031 Mode 00, i_data=8'hA7, o_ready=1 -> next cycle o_valid=1, o_data=12'hAAA, o_sof=1.
REQ-032 Mode 01, i_thresh=8'h80, inputs 8'h7F then 8'h80 -> outputs 12'h000 then 12'hFFF; mode 10, i_data=8'h30 -> 12'hCCC.
REQ-033 o_ready=0, 5 pixels offered back-to-back -> 4 accepted, i_ready=0 after 4th, o_data held at first pixel; raise o_ready -> 4 pixels out in order, one per cycle.
REQ-034 IMG_W=4, IMG_H=2, 8 pixels streamed -> o_sof on pixel 0, o_eol on pixels 3 and 7, o_eof only on pixel 7, o_sof again on pixel 8.
REQ-035 Random i_valid/o_ready toggling over 3 frames -> output sequence equals input sequence converted, count never exceeds 4, no handshake while full on input.
REQ-036 RST low for 1 cycle with 3 pixels buffered at column 5 -> o_valid=0 next cycle, next pixel accepted emerges with o_sof=1.

Source files
------------

// File: rtl/gray2rgb_out_if.sv
// Pixel stream bundle for gray2rgb_out: grayscale input side and RGB444 output side.
// The master drives the grayscale pixels and o_ready; the slave is the converter itself.
interface gray2rgb_out_if;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  i_data;
  logic [1:0]  i_mode;
  logic [7:0]  i_thresh;
  logic        o_valid;
  logic        o_ready;
  logic [11:0] o_data;
  logic        o_sof;
  logic        o_eol;
  logic        o_eof;

  modport master (
    output i_valid, i_data, i_mode, i_thresh, o_ready,
    input  i_ready, o_valid, o_data, o_sof, o_eol, o_eof
  );

  modport slave (
    input  i_valid, i_data, i_mode, i_thresh, o_ready,
    output i_ready, o_valid, o_data, o_sof, o_eol, o_eof
  );
endinterface

// File: rtl/gray2rgb_out.sv
// Grayscale to RGB444 converter with a 4-deep output FIFO and frame position markers.
// Each pixel is converted at input time using the mode/threshold in force at its handshake.
module gray2rgb_out #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic CLK,
  input  logic RST,
  gray2rgb_out_if.slave bus
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [11:0]      mem_q [4];
  logic [11:0]      mem_wdata;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             in_hs;
  logic             out_hs;
  logic             out_valid;
  logic             at_eol;

  function automatic logic [11:0] convert(input logic [7:0] data,
                                          input logic [1:0] mode,
                                          input logic [7:0] thresh);
    logic [3:0] n;
    n = data[7:4];
    case (mode)
      2'b01:   return (data >= thresh) ? 12'hFFF : 12'h000;
      2'b10:   return {~n, ~n, ~n};
      default: return {n, n, n};
    endcase
  endfunction

  // i_ready is gated by RST so nothing is accepted while reset is held.
  assign out_valid   = (count_q != 3'd0);
  assign bus.i_ready = (count_q != 3'd4) && RST;
  assign in_hs       = bus.i_valid && bus.i_ready;
  assign out_hs      = out_valid && bus.o_ready;
  assign mem_wdata   = convert(bus.i_data, bus.i_mode, bus.i_thresh);

  assign at_eol      = out_valid && (col_q == COL_LAST);
  assign bus.o_valid = out_valid;
  assign bus.o_data  = out_valid ? mem_q[rd_ptr_q] : 12'h000;
  assign bus.o_sof   = out_valid && (col_q == '0) && (row_q == '0);
  assign bus.o_eol   = at_eol;
  assign bus.o_eof   = at_eol && (row_q == ROW_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {2'b00, in_hs} - {2'b00, out_hs};
    col_d    = col_q;
    row_d    = row_q;

    if (in_hs) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end

    // Frame position follows the pixel currently leaving, not the one arriving.
    if (out_hs) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (!RST) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      col_d    = '0;
      row_d    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    col_q    <= col_d;
    row_q    <= row_d;
  end

  always_ff @(posedge CLK) begin
    if (in_hs) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_gray2rgb_out.sv
// Self-checking bench for gray2rgb_out: directed scenarios plus randomized traffic
// compared against a queue-based reference of the expected RGB444 stream.
module tb_gray2rgb_out;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int FRAME = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gray2rgb_out_if bus ();

  gray2rgb_out #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          error_count = 0;
  int          check_count = 0;
  logic [11:0] exp_q [$];
  int          out_idx = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    check_count++;
    if (got !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
    end
  endtask

  // Reference conversion written from the pixel rules: 0x111 times the gray level.
  function automatic logic [11:0] refPixel(input logic [7:0] data, input logic [1:0] mode,
                                           input logic [7:0] thresh);
    int level;
    level = int'(data) / 16;
    if (mode == 2'd1) return (int'(data) >= int'(thresh)) ? 12'hFFF : 12'h000;
    if (mode == 2'd2) level = 15 - level;
    return 12'(level * 273);
  endfunction

  task automatic compareToModel();
    bit have;
    have = (exp_q.size() > 0);
    checkOutput("i_ready", bus.i_ready, rst_n && (exp_q.size() < 4));
    checkOutput("o_valid", bus.o_valid, have);
    checkOutput("o_data", bus.o_data, have ? exp_q[0] : 12'h000);
    checkOutput("o_sof", bus.o_sof, have && (out_idx == 0));
    checkOutput("o_eol", bus.o_eol, have && ((out_idx % IMG_W) == IMG_W - 1));
    checkOutput("o_eof", bus.o_eof, have && (out_idx == FRAME - 1));
  endtask

  // Drives one cycle of inputs, advances the reference, then checks after the edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic [1:0] mode,
                               input logic [7:0] thresh, input logic oready, input logic rst_val);
    bit          accept;
    bit          emit;
    logic [11:0] dropped;
    bus.i_valid  = valid;
    bus.i_data   = data;
    bus.i_mode   = mode;
    bus.i_thresh = thresh;
    bus.o_ready  = oready;
    rst_n        = rst_val;
    if (!rst_val) begin
      exp_q.delete();
      out_idx = 0;
    end else begin
      accept = valid && (exp_q.size() < 4);
      emit   = oready && (exp_q.size() > 0);
      if (emit) begin
        dropped = exp_q.pop_front();
        out_idx = (out_idx + 1) % FRAME;
      end
      if (accept) exp_q.push_back(refPixel(data, mode, thresh));
    end
    @(posedge clk);
    @(negedge clk);
    compareToModel();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_data   = 8'h00;
    bus.i_mode   = 2'd0;
    bus.i_thresh = 8'h00;
    bus.o_ready  = 1'b0;

    doReset();
    checkOutput("reset_o_valid", bus.o_valid, 1'b0);
    checkOutput("reset_o_data", bus.o_data, 12'h000);
    checkOutput("reset_i_ready", bus.i_ready, 1'b1);

    // Replicate mode, single-cycle latency into an empty FIFO.
    applyStimulus(1'b1, 8'hA7, 2'd0, 8'h00, 1'b1, 1'b1);
    checkOutput("rep_valid", bus.o_valid, 1'b1);
    checkOutput("rep_data", bus.o_data, 12'hAAA);
    checkOutput("rep_sof", bus.o_sof, 1'b1);
    drain();

    // Threshold boundary and inverted replicate.
    doReset();
    applyStimulus(1'b1, 8'h7F, 2'd1, 8'h80, 1'b1, 1'b1);
    checkOutput("thr_below", bus.o_data, 12'h000);
    applyStimulus(1'b1, 8'h80, 2'd1, 8'h80, 1'b1, 1'b1);
    checkOutput("thr_equal", bus.o_data, 12'hFFF);
    applyStimulus(1'b1, 8'h30, 2'd2, 8'h80, 1'b1, 1'b1);
    checkOutput("inv_data", bus.o_data, 12'hCCC);
    applyStimulus(1'b1, 8'h50, 2'd3, 8'h80, 1'b1, 1'b1);
    checkOutput("mode3_data", bus.o_data, 12'h555);
    drain();

    // Fill with the output stalled: four accepted, the fifth refused.
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 8'((k + 1) * 16), 2'd0, 8'h00, 1'b0, 1'b1);
      if (k >= 3) begin
        checkOutput("full_i_ready", bus.i_ready, 1'b0);
        checkOutput("full_hold", bus.o_data, 12'h111);
      end
    end
    for (int k = 0; k < 4; k++) begin
      logic [11:0] want;
      want = 12'(12'h111 * (k + 1));
      checkOutput("drain_order", bus.o_data, want);
      checkOutput("drain_valid", bus.o_valid, 1'b1);
      applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b1);
    end
    checkOutput("drain_empty", bus.o_valid, 1'b0);

    // Frame markers over one full frame and the first pixel of the next.
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 8'($urandom_range(0, 255)), 2'd0, 8'h00, 1'b1, 1'b1);
      checkOutput("frm_sof", bus.o_sof, (k == 0) || (k == 8));
      checkOutput("frm_eol", bus.o_eol, (k == 3) || (k == 7));
      checkOutput("frm_eof", bus.o_eof, k == 7);
    end
    drain();

    // Reset mid-frame with pixels buffered.
    doReset();
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 8'($urandom_range(0, 255)), 2'd0, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, 8'($urandom_range(0, 255)), 2'd0, 8'h00, 1'b0, 1'b1);
    checkOutput("pre_rst_valid", bus.o_valid, 1'b1);
    applyStimulus(1'b1, 8'h99, 2'd0, 8'h00, 1'b0, 1'b0);
    checkOutput("mid_rst_valid", bus.o_valid, 1'b0);
    checkOutput("mid_rst_ready", bus.i_ready, 1'b0);
    applyStimulus(1'b1, 8'h55, 2'd0, 8'h00, 1'b0, 1'b1);
    checkOutput("post_rst_valid", bus.o_valid, 1'b1);
    checkOutput("post_rst_sof", bus.o_sof, 1'b1);
    checkOutput("post_rst_data", bus.o_data, 12'h555);
    drain();

    // Random traffic covering several frames with per-pixel mode changes.
    doReset();
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
                    2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 9) < 5), 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
